// File: rtl/fpu_pkg.sv
// Shared binary32 helpers and the min/max reducer state encoding.
package fpu_pkg;

    localparam int FLT_W = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FLT_W-1:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } fmr_state_t;

    function automatic logic is_nan(input logic [FLT_W-1:0] f);
        return (f[FLT_W-2 -: EXP_W] == '1) && (f[MAN_W-1:0] != '0);
    endfunction

    function automatic logic is_zero(input logic [FLT_W-1:0] f);
        return f[FLT_W-2:0] == '0;
    endfunction

endpackage

// File: rtl/fcmp_lt.sv
// Combinational binary32 a<b: false on any NaN operand, +0 and -0 compare equal.
module fcmp_lt
    import fpu_pkg::*;
(
    input  logic [FLT_W-1:0] i_a,
    input  logic [FLT_W-1:0] i_b,
    output logic             o_lt
);

    logic w_mag_lt;
    logic w_mag_gt;
    logic w_unordered;

    assign w_mag_lt    = i_a[FLT_W-2:0] < i_b[FLT_W-2:0];
    assign w_mag_gt    = i_b[FLT_W-2:0] < i_a[FLT_W-2:0];
    assign w_unordered = is_nan(i_a) || is_nan(i_b) || (is_zero(i_a) && is_zero(i_b));

    // Sign-magnitude order: negatives compare with reversed magnitude.
    always_comb begin
        o_lt = 1'b0;
        if (!w_unordered) begin
            case ({i_a[FLT_W-1], i_b[FLT_W-1]})
                2'b00:   o_lt = w_mag_lt;
                2'b11:   o_lt = w_mag_gt;
                2'b10:   o_lt = 1'b1;
                default: o_lt = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fminmax_reduce.sv
// Streaming binary32 min/max reducer: one result beat per s_last-terminated packet.
module fminmax_reduce
    import fpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_min,
    output logic [31:0]      m_max,
    output logic [CNT_W-1:0] m_count,
    output logic             m_nan
);

    fmr_state_t       r_state;
    fmr_state_t       w_state_nxt;
    logic             r_s_ready;
    logic             r_m_valid;
    logic [31:0]      r_min;
    logic [31:0]      r_max;
    logic [CNT_W-1:0] r_count;
    logic             r_nan;
    logic             r_seen;

    logic             w_acc;
    logic             w_take;
    logic             w_x_nan;
    logic             w_x_lt_min;
    logic             w_max_lt_x;
    logic             w_s_ready_nxt;
    logic             w_m_valid_nxt;

    assign w_acc   = s_valid && r_s_ready;
    assign w_take  = r_m_valid && m_ready;
    assign w_x_nan = is_nan(s_data);

    fcmp_lt u_lt_min (
        .i_a  (s_data),
        .i_b  (r_min),
        .o_lt (w_x_lt_min)
    );

    fcmp_lt u_lt_max (
        .i_a  (r_max),
        .i_b  (s_data),
        .o_lt (w_max_lt_x)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_state_nxt = s_last ? HOLD : ACC;
            ACC:     if (w_acc && s_last) w_state_nxt = HOLD;
            HOLD:    if (m_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Handshake flags are registered from the next state, so s_ready never sees m_ready combinationally.
        w_s_ready_nxt = (w_state_nxt != HOLD);
        w_m_valid_nxt = (w_state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= w_s_ready_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

    // Accumulators are cleared on reset and whenever a result is consumed (entry to IDLE).
    always_ff @(posedge clk) begin
        if (!rstn || w_take) begin
            r_min   <= QNAN;
            r_max   <= QNAN;
            r_count <= '0;
            r_nan   <= 1'b0;
            r_seen  <= 1'b0;
        end else if (w_acc) begin
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
            if (w_x_nan) begin
                r_nan <= 1'b1;
            end else if (!r_seen) begin
                r_min  <= s_data;
                r_max  <= s_data;
                r_seen <= 1'b1;
            end else begin
                if (w_x_lt_min) r_min <= s_data;
                if (w_max_lt_x) r_max <= s_data;
            end
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_min   = r_min;
    assign m_max   = r_max;
    assign m_count = r_count;
    assign m_nan   = r_nan;

endmodule

// File: tb/tb_fminmax_reduce.sv
// Directed, table-driven bench for fminmax_reduce with hand-computed expectations.
module tb_fminmax_reduce;

    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [31:0]         s_data = '0;
    logic                s_last = 1'b0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [31:0]         m_min;
    logic [31:0]         m_max;
    logic [TB_CNT_W-1:0] m_count;
    logic                m_nan;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned n;
        logic [31:0] d [4];
        logic [31:0] emin;
        logic [31:0] emax;
        int unsigned ecnt;
        logic        enan;
    } vec_t;

    vec_t vecs [8];

    fminmax_reduce #(.CNT_W(TB_CNT_W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_min   (m_min),
        .m_max   (m_max),
        .m_count (m_count),
        .m_nan   (m_nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int idx, input int unsigned n,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [31:0] emin, input logic [31:0] emax,
                        input int unsigned ecnt, input logic enan);
        vecs[idx].n    = n;
        vecs[idx].d[0] = d0;
        vecs[idx].d[1] = d1;
        vecs[idx].d[2] = d2;
        vecs[idx].d[3] = d3;
        vecs[idx].emin = emin;
        vecs[idx].emax = emax;
        vecs[idx].ecnt = ecnt;
        vecs[idx].enan = enan;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        int waited;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waited  = 0;
        while (!s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", 32'(s_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_pkt(input string name, input logic [31:0] emin, input logic [31:0] emax,
                              input int unsigned ecnt, input logic enan);
        @(negedge clk);
        chk({name, "_latency_mvalid"}, 32'(m_valid), 32'd1);
        chk({name, "_min"},   m_min, emin);
        chk({name, "_max"},   m_max, emax);
        chk({name, "_count"}, 32'(m_count), ecnt);
        chk({name, "_nan"},   32'(m_nan), 32'(enan));
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk({name, "_post_mvalid"}, 32'(m_valid), 32'd0);
        chk({name, "_post_sready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        setv(0, 3, 32'h40400000, 32'hBFC00000, 32'h40E80000, 32'h0, 32'hBFC00000, 32'h40E80000, 3, 1'b0);
        setv(1, 2, 32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h00000000, 32'h00000000, 2, 1'b0);
        setv(2, 3, 32'h7FC00001, 32'h3F800000, 32'hFF800000, 32'h0, 32'hFF800000, 32'h3F800000, 3, 1'b1);
        setv(3, 1, 32'h7F800001, 32'h0, 32'h0, 32'h0, 32'h7FC00000, 32'h7FC00000, 1, 1'b1);
        setv(4, 3, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h0, 32'h80000000, 32'h3F800000, 3, 1'b0);
        setv(5, 4, 32'hC0000000, 32'hC0400000, 32'hBF800000, 32'h7F800000, 32'hC0400000, 32'h7F800000, 4, 1'b0);
        setv(6, 4, 32'h3F800000, 32'h7FC00000, 32'h3F000000, 32'hFF800001, 32'h3F000000, 32'h3F800000, 4, 1'b1);
        setv(7, 2, 32'h7F7FFFFF, 32'h7F800000, 32'h0, 32'h0, 32'h7F7FFFFF, 32'h7F800000, 2, 1'b0);

        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_sready", 32'(s_ready), 32'd1);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_min",    m_min, 32'h7FC00000);
        chk("rst_max",    m_max, 32'h7FC00000);
        chk("rst_count",  32'(m_count), 32'd0);
        chk("rst_nan",    32'(m_nan), 32'd0);

        for (int v = 0; v < 8; v++) begin
            for (int unsigned b = 0; b < vecs[v].n; b++) begin
                beat(vecs[v].d[b], b == vecs[v].n - 1);
            end
            finish_pkt($sformatf("vec%0d", v), vecs[v].emin, vecs[v].emax, vecs[v].ecnt, vecs[v].enan);
        end

        // Backpressure: outputs frozen while m_ready is low.
        beat(32'h40400000, 1'b0);
        beat(32'hBFC00000, 1'b0);
        beat(32'h40E80000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_mvalid", 32'(m_valid), 32'd1);
            chk("bp_sready", 32'(s_ready), 32'd0);
            chk("bp_min",    m_min, 32'hBFC00000);
            chk("bp_max",    m_max, 32'h40E80000);
            chk("bp_count",  32'(m_count), 32'd3);
        end
        // m_ready and s_valid together in HOLD: consume only, accept next cycle.
        s_valid = 1'b1;
        s_data  = 32'h40000000;
        s_last  = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("hold_both_mvalid", 32'(m_valid), 32'd0);
        chk("hold_both_sready", 32'(s_ready), 32'd1);
        chk("hold_both_count",  32'(m_count), 32'd0);
        @(negedge clk);
        chk("hold_next_mvalid", 32'(m_valid), 32'd1);
        chk("hold_next_min",    m_min, 32'h40000000);
        chk("hold_next_count",  32'(m_count), 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("hold_done_mvalid", 32'(m_valid), 32'd0);

        // Reset mid-packet discards the partial result.
        beat(32'h3F800000, 1'b0);
        beat(32'hC0000000, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_sready", 32'(s_ready), 32'd1);
        chk("mid_rst_min",    m_min, 32'h7FC00000);
        chk("mid_rst_max",    m_max, 32'h7FC00000);
        chk("mid_rst_count",  32'(m_count), 32'd0);
        chk("mid_rst_nan",    32'(m_nan), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_rst_no_mvalid", 32'(m_valid), 32'd0);
            @(negedge clk);
        end
        beat(32'h40000000, 1'b1);
        finish_pkt("post_rst", 32'h40000000, 32'h40000000, 1, 1'b0);

        // Counter saturates at all-ones (15 for a 4-bit counter) without wrapping.
        for (int b = 0; b < 18; b++) begin
            beat(32'h3F800000, b == 17);
        end
        finish_pkt("sat", 32'h3F800000, 32'h3F800000, 15, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fminmax_reduce.md
# fminmax_reduce

Streaming single-precision min/max reducer placed directly downstream of the FPU less-than comparator datapath. It accepts a packet of IEEE-754 binary32 values over a valid/ready stream terminated by `s_last`. It tracks the running minimum and maximum using less-than ordering, then emits one result beat per packet. The block backs the vector-reduction instructions and frees the core from looping compare/select sequences.

## Interface
Parameters:
- `CNT_W`, 16, width of the element counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept an input beat.
- `s_data`  in  32  binary32 operand.
- `s_last`  in  1  marks the final beat of the packet.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumer ready.
- `m_min`  out  32  packet minimum.
- `m_max`  out  32  packet maximum.
- `m_count`  out  CNT_W  number of beats accepted in the packet, saturating.
- `m_nan`  out  1  at least one NaN operand was seen in the packet.

## Operation
- Handshake rules:
  - An input beat is accepted when `s_valid && s_ready`.
  - A result is consumed when `m_valid && m_ready`.
- FSM states:
  - `IDLE`: `s_ready`=1, no packet open. An accepted beat moves to `ACC`, or to `HOLD` if `s_last`=1.
  - `ACC`: `s_ready`=1. Each accepted beat updates the running state. An accepted beat with `s_last`=1 moves to `HOLD`.
  - `HOLD`: `s_ready`=0, `m_valid`=1. The outputs stay stable until `m_ready`=1, then the block returns to `IDLE`.
- Ordering:
  - NaN is any value with exp=8'hFF and mantissa≠0.
  - Ordering uses the same less-than semantics as the comparator, with +0 and −0 equal.
  - Sign-magnitude order applies otherwise.
  - ±Inf are ordinary extremes.
- Update rule for an accepted non-NaN beat `x`:
  - If no non-NaN value has been seen yet in the packet, min=max=x.
  - Else min←x only if x<min; max←x only if max<x.
  - On ties (including ±0) the earlier value is retained bit-exact.
- A NaN beat:
  - sets the sticky NaN flag;
  - leaves min/max unchanged;
  - still increments the count.
- All-NaN packet: `m_min`=`m_max`=32'h7FC00000 (canonical qNaN), `m_nan`=1.
- Counter:
  - resets to 0 on entering `IDLE`;
  - increments per accepted beat;
  - saturates at all-ones with no wrap.
- A packet may be a single beat (`s_last` on the first beat).
- Reset asserted mid-packet or in `HOLD` discards the partial or pending result with no output beat.

## Timing
- Reset values:
  - `s_ready`=1, `m_valid`=0;
  - `m_min`=`m_max`=32'h7FC00000;
  - `m_count`=0, `m_nan`=0;
  - FSM=`IDLE`.
- Latency: `m_valid` rises the cycle after the `s_last` beat is accepted, i.e. one cycle.
- Throughput:
  - one beat per cycle within a packet;
  - one bubble cycle per packet minimum, because `HOLD` blocks input.
  - Back-to-back packets with `m_ready` tied high sustain N+1 cycles per N-beat packet.
- `s_ready` is a registered function of state only, with no combinational path from `m_ready`.
- `m_*` are driven from registers and stay stable while `m_valid && !m_ready`.
- Simultaneous `m_ready` and `s_valid` in `HOLD`: the result is consumed and the input is not accepted that cycle. The next beat is accepted in `IDLE` on the following cycle.

## Structure
- Shared package `fpu_pkg`:
  - `FLT_W`=32, `EXP_W`=8, `MAN_W`=23;
  - `QNAN`=32'h7FC00000;
  - `is_nan`/`is_zero` functions;
  - FSM enum `fmr_state_t {IDLE, ACC, HOLD}`.
- One sub-module `fcmp_lt`: a combinational binary32 a<b returning 0 when either operand is NaN and treating ±0 as equal. It is instantiated twice, once for `x<min` and once for `max<x`.
- Top-level holds the FSM, the min/max/count/NaN registers and the handshake logic.

## Test plan
- Packet {3.0 (40400000), −1.5 (BFC00000), 7.25 (40E80000) last}, `m_ready`=1 → `m_min`=BFC00000, `m_max`=40E80000, `m_count`=3, `m_nan`=0.
- Packet {+0 (00000000), −0 (80000000) last} → `m_min`=`m_max`=00000000 (first retained), `m_count`=2.
- Packet {7FC00001, 3F800000, FF800000 last} → `m_min`=FF800000, `m_max`=3F800000, `m_nan`=1, `m_count`=3.
- Single-beat all-NaN packet {7F800001 last} → `m_min`=`m_max`=7FC00000, `m_nan`=1, `m_count`=1.
- Backpressure: hold `m_ready`=0 for 5 cycles after the result → `s_ready`=0 and outputs stable throughout; `m_ready`=1 → next cycle `s_ready`=1.
- Reset mid-packet:
  - accept 2 beats, drive `rstn`=0 for one cycle → outputs return to reset values and no `m_valid` pulse;
  - a fresh single-beat packet {40000000 last} → `m_count`=1.
